// File: rtl/param_queue_pkg.sv
// Shared definitions for the parametrised instruction queue.
// Latency: n/a (types, defaults and helpers only).
// Backpressure: n/a.
package param_queue_pkg;

  // Default geometry of the fetch->decode buffer.
  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_DEPTH    = 8;
  localparam int unsigned DEF_AF_LEVEL = 6;

  // Sticky error flags, kept together so they reset/retain as one unit.
  typedef struct packed {
    logic ovf;  // push rejected while full without a pop
    logic udf;  // pop requested while empty
  } sticky_t;

  // Effective operations after qualification against occupancy.
  typedef struct packed {
    logic push;
    logic pop;
  } q_op_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/param_queue_ram.sv
// DEPTH x WIDTH register-array storage: one synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge; read data follows raddr_i combinationally.
// Backpressure: none; the caller only writes slots it owns.
module param_queue_ram
  import param_queue_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Storage is deliberately never reset; contents are only meaningful
  // between head and tail, which the owner tracks.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: capture the word into the addressed slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is a plain mux so the head word falls through without a cycle of delay.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_queue.sv
// Parametrised synchronous FIFO (fetch->decode buffer) with count, almost-full, flush and sticky error flags.
// Latency: pushed word visible on front one edge after the push; pop advances front on the next edge.
// Backpressure: push at full is dropped unless a pop is accepted that same cycle; overflow/underflow latch sticky.
module param_queue
  import param_queue_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         rear,
  input  logic                     pop,
  output logic [WIDTH-1:0]         front,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Reject geometries the pointer arithmetic cannot support.
  generate
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("param_queue: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("param_queue: AF_LEVEL must lie in 1..DEPTH");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  sticky_t       sticky_q, sticky_d;

  // Occupancy decode comes from the counter, not pointer comparison,
  // so full and empty are unambiguous when head == tail.
  logic is_empty;
  logic is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // ---------------------------------------------------------------------------
  // Operation qualification
  // ---------------------------------------------------------------------------
  q_op_t op;
  logic  ovf_event;
  logic  udf_event;
  logic  ram_we;

  // Qualify requests: pop needs data; push needs room or a pop freeing a slot this cycle.
  // Flush overrides both and suppresses flagging.
  always_comb begin
    op.pop    = pop & ~is_empty & ~flush;
    op.push   = push & (~is_full | (pop & ~is_empty)) & ~flush;
    ovf_event = push & is_full & ~pop & ~flush;
    udf_event = pop & is_empty & ~flush;
    ram_we    = op.push & rst;
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  param_queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (tail_q),
    .wdata_i (rear),
    .raddr_i (head_q),
    .rdata_o (front)
  );

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------

  // Pointer/counter/flag update; flush clears occupancy but keeps the sticky flags.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits so wrap-around is free.
      if (op.push) begin
        tail_d = tail_q + AW'(1);
      end
      if (op.pop) begin
        head_d = head_q + AW'(1);
      end
      // Simultaneous push and pop leaves occupancy untouched.
      unique case ({op.push, op.pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (ovf_event) begin
      sticky_d.ovf = 1'b1;
    end
    if (udf_event) begin
      sticky_d.udf = 1'b1;
    end
  end

  // State register with synchronous active-low reset; reset outranks flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registered state or a direct decode of it, never an input.
  // ---------------------------------------------------------------------------
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign count       = count_q;
  assign overflow    = sticky_q.ovf;
  assign underflow   = sticky_q.udf;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------

  // Occupancy can never exceed the array and must agree with the pointer distance.
  always @(posedge clk) begin
    if (rst) begin
      assert (count_q <= CW'(DEPTH))
        else $error("param_queue: count exceeds DEPTH");
      assert (AW'(count_q) == AW'(tail_q - head_q))
        else $error("param_queue: count disagrees with pointers");
    end
  end

endmodule

// File: tb/tb_param_queue.sv
module tb_param_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, push, pop;
  logic [31:0] rear;

  // Instance 0: WIDTH=32 DEPTH=8 AF=6.  Instance 1: WIDTH=8 DEPTH=2 AF=2.
  logic [31:0] front0;
  logic [7:0]  front1;
  logic        empty0, full0, af0, ovf0, udf0;
  logic        empty1, full1, af1, ovf1, udf1;
  logic [3:0]  count0;
  logic [1:0]  count1;

  param_queue #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(6)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .rear(rear), .pop(pop),
    .front(front0), .empty(empty0), .full(full0), .almost_full(af0),
    .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  param_queue #(.WIDTH(8), .DEPTH(2), .AF_LEVEL(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .rear(rear[7:0]), .pop(pop),
    .front(front1), .empty(empty1), .full(full1), .almost_full(af1),
    .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  // Uniform views of both instances.
  logic [31:0] a_front [2];
  logic [31:0] a_count [2];
  logic        a_empty [2], a_full [2], a_af [2], a_ovf [2], a_udf [2];
  assign a_front[0] = front0;           assign a_front[1] = {24'h0, front1};
  assign a_count[0] = {28'h0, count0};  assign a_count[1] = {30'h0, count1};
  assign a_empty[0] = empty0;           assign a_empty[1] = empty1;
  assign a_full[0]  = full0;            assign a_full[1]  = full1;
  assign a_af[0]    = af0;              assign a_af[1]    = af1;
  assign a_ovf[0]   = ovf0;             assign a_ovf[1]   = ovf1;
  assign a_udf[0]   = udf0;             assign a_udf[1]   = udf1;

  int          dep [2] = '{8, 2};
  int          afl [2] = '{6, 2};
  logic [31:0] msk [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // Reference model: occupancy, sticky flags, and the expected output order.
  int          m_cnt [2];
  bit          m_ovf [2], m_udf [2];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];

  function automatic int sb_size(input int i);
    return (i == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic [31:0] sb_front(input int i);
    return (i == 0) ? exp0[0] : exp1[0];
  endfunction

  task automatic sb_push(input int i, input logic [31:0] d);
    if (i == 0) exp0.push_back(d); else exp1.push_back(d);
  endtask

  task automatic sb_pop(input int i);
    if (i == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
  endtask

  task automatic sb_clear(input int i);
    if (i == 0) exp0.delete(); else exp1.delete();
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (depth %0d) at %0t: actual %0h required %0h", nm, dep[i], $time, act, req);
    end
  endtask

  // Model update on every rising edge from the queue rules.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        sb_clear(i);
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
        m_udf[i] = 1'b0;
      end else if (flush) begin
        sb_clear(i);
        m_cnt[i] = 0;
      end else begin
        bit pop_ok, push_ok;
        pop_ok  = pop && (m_cnt[i] > 0);
        push_ok = push && ((m_cnt[i] < dep[i]) || pop_ok);
        if (pop && m_cnt[i] == 0) m_udf[i] = 1'b1;
        if (push && !push_ok)     m_ovf[i] = 1'b1;
        if (push_ok) sb_push(i, rear & msk[i]);
        m_cnt[i] = m_cnt[i] + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
      end
    end
    if (!rst) started = 1'b1;
  end

  // Monitor: compare status every cycle; front against the scoreboard head,
  // consuming it when the DUT hands the word over.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("count",       i, a_count[i], m_cnt[i]);
        chk("empty",       i, {31'h0, a_empty[i]}, {31'h0, m_cnt[i] == 0});
        chk("full",        i, {31'h0, a_full[i]},  {31'h0, m_cnt[i] == dep[i]});
        chk("almost_full", i, {31'h0, a_af[i]},    {31'h0, m_cnt[i] >= afl[i]});
        chk("overflow",    i, {31'h0, a_ovf[i]},   {31'h0, m_ovf[i]});
        chk("underflow",   i, {31'h0, a_udf[i]},   {31'h0, m_udf[i]});
        if (!a_empty[i]) begin
          if (sb_size(i) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL front (depth %0d) at %0t: actual %0h required no data", dep[i], $time, a_front[i]);
          end else begin
            chk("front", i, a_front[i], sb_front(i));
            if (pop && rst && !flush) sb_pop(i);
          end
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit f, input bit pu, input bit po, input logic [31:0] d);
    rst = r; flush = f; push = pu; pop = po; rear = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; rear = '0;

    // Reset held two cycles, then released.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // Fill 1..9 (ninth overflows), drain with one extra pop.
    for (int k = 1; k <= 9; k++) cyc(1, 0, 1, 0, k);
    for (int k = 0; k < 9; k++)  cyc(1, 0, 0, 1, 0);

    // Pointer wrap.
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, 0, 32'h10 + k);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) cyc(1, 0, 1, 0, 32'hA0 + k);
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, 1, 0);

    // Simultaneous push+pop at full, then at empty.
    for (int k = 0; k < 8; k++) cyc(1, 0, 1, 0, 32'hB0 + k);
    cyc(1, 0, 1, 1, 32'h55);
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 32'h77);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);

    // Flush with a same-cycle push, then a fresh push.
    for (int k = 0; k < 4; k++) cyc(1, 0, 1, 0, 32'hC0 + k);
    cyc(1, 1, 1, 0, 32'h99);
    cyc(1, 0, 1, 0, 32'h11);
    cyc(1, 0, 0, 1, 0);

    // Reset mid-operation with push asserted.
    for (int k = 0; k < 9; k++) cyc(1, 0, 1, 0, 32'hD0 + k);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 32'hEE);
    cyc(1, 0, 0, 0, 0);

    // Randomised traffic with phases biased toward full, balanced, and empty.
    for (int n = 0; n < 3000; n++) begin
      int ph, pp, pq;
      ph = (n / 150) % 3;
      pp = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
      pq = 100 - pp;
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 99) < pp),
          ($urandom_range(0, 99) < pq),
          $urandom);
    end

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
